// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear scaler frame controller.
// Watchdog logic in the top is built only with BILINEAR_VSYNC_WDOG_EN.
package bilinear_pkg;

   typedef enum logic [1:0] {
      StWaitCfg = 2'd0,
      StSync    = 2'd1,
      StRun     = 2'd2,
      StLost    = 2'd3
   } bl_state_e;

   localparam int unsigned DimWidth = 12;
   localparam int unsigned WdWidth  = 24;

   localparam logic [DimWidth-1:0] DefWidth  = 12'd2560;
   localparam logic [DimWidth-1:0] DefHeight = 12'd1440;
   localparam logic [DimWidth-1:0] MinWidth  = 12'd64;
   localparam logic [DimWidth-1:0] MaxWidth  = 12'd2560;
   localparam logic [DimWidth-1:0] MinHeight = 12'd48;
   localparam logic [DimWidth-1:0] MaxHeight = 12'd1440;

   localparam logic [WdWidth-1:0] DefWdCycles = 24'd4_000_000;

endpackage

// File: rtl/res_clamp.sv
// Combinational clamp of one destination dimension into [Min, Max].
// changed_o flags that the output differs from the request.
module res_clamp
   import bilinear_pkg::*;
#(
   parameter logic [DimWidth-1:0] Min = 12'd1,
   parameter logic [DimWidth-1:0] Max = 12'd4095
) (
   input  logic [DimWidth-1:0] val_i,
   output logic [DimWidth-1:0] val_o,
   output logic                changed_o
);

   always_comb begin
      val_o     = val_i;
      changed_o = 1'b0;
      if (val_i < Min) begin
         val_o     = Min;
         changed_o = 1'b1;
      end else if (val_i > Max) begin
         val_o     = Max;
         changed_o = 1'b1;
      end
   end

endmodule

// File: rtl/bilinear_scale_ctrl.sv
// Frame-synchronous resolution controller and enable gate for the bilinear scaler.
// Define BILINEAR_VSYNC_WDOG_EN to build the vsync watchdog and LOST state.
module bilinear_scale_ctrl
   import bilinear_pkg::*;
#(
   parameter logic [DimWidth-1:0] DEF_W     = DefWidth,
   parameter logic [DimWidth-1:0] DEF_H     = DefHeight,
   parameter logic [DimWidth-1:0] MIN_W     = MinWidth,
   parameter logic [DimWidth-1:0] MAX_W     = MaxWidth,
   parameter logic [DimWidth-1:0] MIN_H     = MinHeight,
   parameter logic [DimWidth-1:0] MAX_H     = MaxHeight,
   parameter logic [WdWidth-1:0]  WD_CYCLES = DefWdCycles
) (
   input  logic                biliner_clk_in,
   input  logic                sys_rst_n,
   input  logic                ADV7611_config_done,
   input  logic                vsync_i,
   input  logic                cfg_valid,
   input  logic [DimWidth-1:0] cfg_width,
   input  logic [DimWidth-1:0] cfg_height,
   output logic                cfg_ready,
   output logic [DimWidth-1:0] c_dst_img_width,
   output logic [DimWidth-1:0] c_dst_img_height,
   output logic                scaler_en,
   output logic                apply_pulse,
   output logic                cfg_clamped,
   output logic [15:0]         frame_cnt,
   output logic                lost
);

   bl_state_e           state_q, state_d;
   logic                vs_q;
   logic                vs_rise;
   logic                pend_q;
   logic [DimWidth-1:0] pend_w_q, pend_h_q;
   logic [DimWidth-1:0] cl_w, cl_h;
   logic                chg_w, chg_h;
   logic                accept;
   logic                apply;
   logic                wd_expire;

   res_clamp #(
      .Min (MIN_W),
      .Max (MAX_W)
   ) u_clamp_w (
      .val_i     (cfg_width),
      .val_o     (cl_w),
      .changed_o (chg_w)
   );

   res_clamp #(
      .Min (MIN_H),
      .Max (MAX_H)
   ) u_clamp_h (
      .val_i     (cfg_height),
      .val_o     (cl_h),
      .changed_o (chg_h)
   );

   assign vs_rise   = vsync_i & ~vs_q;
   assign cfg_ready = ~pend_q;
   assign accept    = cfg_valid & ~pend_q;
   // Apply uses the pre-edge slot, so a same-cycle acceptance waits a frame.
   assign apply     = vs_rise & pend_q & (state_q != StWaitCfg);

`ifdef BILINEAR_VSYNC_WDOG_EN
   logic [WdWidth-1:0] wd_q, wd_d;
   logic               lost_q;

   always_comb begin
      wd_d = wd_q;
      if (vs_rise) begin
         wd_d = '0;
      end else if (state_q == StRun) begin
         wd_d = wd_q + 1'b1;
      end
   end

   assign wd_expire = (state_q == StRun) & ~vs_rise & (wd_d >= WD_CYCLES);
   assign lost      = lost_q;

   always_ff @(posedge biliner_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wd_q   <= '0;
         lost_q <= 1'b0;
      end else begin
         wd_q   <= wd_d;
         lost_q <= (state_d == StLost);
      end
   end
`else
   logic unused_wd_cycles;

   assign unused_wd_cycles = ^WD_CYCLES;
   assign wd_expire        = 1'b0;
   assign lost             = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWaitCfg: state_d = StSync;
         StSync:    if (vs_rise) state_d = StRun;
         StRun:     if (wd_expire) state_d = StLost;
         StLost:    if (vs_rise) state_d = StRun;
         default:   state_d = StWaitCfg;
      endcase
      if (!ADV7611_config_done) begin
         state_d = StWaitCfg;
      end
   end

   always_ff @(posedge biliner_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q          <= StWaitCfg;
         vs_q             <= 1'b0;
         pend_q           <= 1'b0;
         pend_w_q         <= '0;
         pend_h_q         <= '0;
         c_dst_img_width  <= DEF_W;
         c_dst_img_height <= DEF_H;
         scaler_en        <= 1'b0;
         apply_pulse      <= 1'b0;
         cfg_clamped      <= 1'b0;
         frame_cnt        <= '0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vsync_i;
         scaler_en   <= (state_d == StRun);
         apply_pulse <= apply;
         cfg_clamped <= accept & (chg_w | chg_h);
         if (accept) begin
            pend_q   <= 1'b1;
            pend_w_q <= cl_w;
            pend_h_q <= cl_h;
         end else if (apply) begin
            pend_q <= 1'b0;
         end
         if (apply) begin
            c_dst_img_width  <= pend_w_q;
            c_dst_img_height <= pend_h_q;
         end
         if (vs_rise && (state_q == StRun)) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_bilinear_scale_ctrl.sv
// Directed plus randomized bench for bilinear_scale_ctrl against a frame-level model.
// Watchdog checks follow BILINEAR_VSYNC_WDOG_EN, matching the DUT build.
module tb_bilinear_scale_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_done;
   logic        vsync;
   logic        cfg_valid;
   logic [11:0] cfg_width, cfg_height;
   logic        cfg_ready;
   logic [11:0] dst_w, dst_h;
   logic        scaler_en, apply_pulse, cfg_clamped, lost;
   logic [15:0] frame_cnt;

   int errors = 0;
   int checks = 0;

   // Model: mode 0 = waiting for config, 1 = syncing, 2 = running, 3 = lost.
   int          m_mode;
   int          m_frames;
   bit          m_pend;
   int          m_w, m_h, m_pw, m_ph;

   always #5 clk = ~clk;

   bilinear_scale_ctrl #(
      .WD_CYCLES (24'd100)
   ) dut (
      .biliner_clk_in      (clk),
      .sys_rst_n           (rst_n),
      .ADV7611_config_done (cfg_done),
      .vsync_i             (vsync),
      .cfg_valid           (cfg_valid),
      .cfg_width           (cfg_width),
      .cfg_height          (cfg_height),
      .cfg_ready           (cfg_ready),
      .c_dst_img_width     (dst_w),
      .c_dst_img_height    (dst_h),
      .scaler_en           (scaler_en),
      .apply_pulse         (apply_pulse),
      .cfg_clamped         (cfg_clamped),
      .frame_cnt           (frame_cnt),
      .lost                (lost)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      vsync = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // One-cycle vsync pulse; checks what the frame boundary should have done.
   task automatic vs_pulse(input string tag);
      bit exp_apply;
      exp_apply = 1'b0;
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      if (m_mode != 0) begin
         if (m_pend) begin
            exp_apply = 1'b1;
            m_w = m_pw;
            m_h = m_ph;
            m_pend = 1'b0;
         end
         if (m_mode == 2) m_frames = (m_frames + 1) % 65536;
         m_mode = 2;
      end
      chk({tag, ".scaler_en"}, scaler_en, (m_mode == 2));
      chk({tag, ".apply"}, apply_pulse, exp_apply);
      chk({tag, ".width"}, dst_w, m_w);
      chk({tag, ".height"}, dst_h, m_h);
      chk({tag, ".frames"}, frame_cnt, m_frames);
      chk({tag, ".lost"}, lost, 1'b0);
   endtask

   task automatic request(input string tag, input int w, input int h);
      int cw, ch;
      chk({tag, ".ready_before"}, cfg_ready, !m_pend);
      cfg_valid  = 1'b1;
      cfg_width  = w[11:0];
      cfg_height = h[11:0];
      step();
      cfg_valid = 1'b0;
      cw = clampv(w, 64, 2560);
      ch = clampv(h, 48, 1440);
      m_pend = 1'b1;
      m_pw = cw;
      m_ph = ch;
      chk({tag, ".clamped"}, cfg_clamped, (cw != w) || (ch != h));
      chk({tag, ".ready_after"}, cfg_ready, 1'b0);
      step();
      chk({tag, ".clamped_off"}, cfg_clamped, 1'b0);
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_frames = 0;
      m_pend = 1'b0;
      m_w = 2560;
      m_h = 1440;
      m_pw = 0;
      m_ph = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".width"}, dst_w, 2560);
      chk({tag, ".height"}, dst_h, 1440);
      chk({tag, ".scaler_en"}, scaler_en, 1'b0);
      chk({tag, ".apply"}, apply_pulse, 1'b0);
      chk({tag, ".clamped"}, cfg_clamped, 1'b0);
      chk({tag, ".lost"}, lost, 1'b0);
      chk({tag, ".frames"}, frame_cnt, 0);
      chk({tag, ".ready"}, cfg_ready, 1'b1);
   endtask

   initial begin
      int w, h, cnt;
      rst_n = 1'b0;
      cfg_done = 1'b0;
      vsync = 1'b0;
      cfg_valid = 1'b0;
      cfg_width = '0;
      cfg_height = '0;
      model_reset();
      for (int i = 0; i < 3; i++) step();
      chk_reset("reset");
      rst_n = 1'b1;
      step();

      // Bring-up: config done, then first vsync enters RUN.
      cfg_done = 1'b1;
      gap(1000);
      m_mode = 1;
      chk("sync.scaler_off", scaler_en, 1'b0);
      vs_pulse("first_vs");
      for (int i = 0; i < 3; i++) begin
         gap(999);
         vs_pulse("frame");
      end
      chk("frames_three", frame_cnt, 3);

      // Mid-frame request, held until the boundary.
      gap(300);
      request("req1920", 1920, 1080);
      gap(200);
      chk("hold.width", dst_w, 2560);
      chk("hold.height", dst_h, 1440);
      vs_pulse("apply1920");
      chk("ready_after_apply", cfg_ready, 1'b1);
      step();
      chk("apply_one_cycle", apply_pulse, 1'b0);

      // Out-of-range request clamps to 2560x48.
      gap(100);
      request("req4000x0", 4000, 0);
      gap(100);
      vs_pulse("apply_clamped");

      // Randomized requests against the model clamp.
      for (int i = 0; i < 8; i++) begin
         w = $urandom_range(0, 4095);
         h = $urandom_range(0, 4095);
         if (i == 0) w = 64;
         if (i == 1) h = 1440;
         gap($urandom_range(5, 150));
         request("rand", w, h);
         gap($urandom_range(5, 150));
         vs_pulse("rand_apply");
      end

      // Request in the same cycle as vs_rise waits a frame; second request is refused.
      gap(50);
      cfg_valid = 1'b1;
      cfg_width = 12'd800;
      cfg_height = 12'd600;
      vs_pulse("coincide");
      cfg_valid = 1'b0;
      m_pend = 1'b1;
      m_pw = 800;
      m_ph = 600;
      chk("coincide.ready", cfg_ready, 1'b0);
      cfg_valid = 1'b1;
      cfg_width = 12'd4000;
      cfg_height = 12'd5;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("second.ready", cfg_ready, 1'b0);
         chk("second.no_clamp", cfg_clamped, 1'b0);
      end
      cfg_valid = 1'b0;
      gap(50);
      vs_pulse("coincide_apply");
      gap(50);
      vs_pulse("no_stale_apply");

      // Drop config in RUN with a request pending across WAIT_CFG.
      gap(20);
      request("req_pend_wait", 1280, 720);
      cfg_done = 1'b0;
      step();
      m_mode = 0;
      chk("drop.scaler_en", scaler_en, 1'b0);
      chk("drop.width", dst_w, m_w);
      chk("drop.height", dst_h, m_h);
      gap(30);
      vs_pulse("vs_in_wait");
      cfg_done = 1'b1;
      step();
      m_mode = 1;
      gap(20);
      chk("resync.scaler_off", scaler_en, 1'b0);
      vs_pulse("resync");

      // Stop vsync.
      gap(10);
      vs_pulse("before_stop");
`ifdef BILINEAR_VSYNC_WDOG_EN
      cnt = 0;
      while (lost !== 1'b1 && cnt < 300) begin
         step();
         cnt++;
      end
      chk("wdog.latency", cnt, 100);
      chk("wdog.lost", lost, 1'b1);
      chk("wdog.scaler_off", scaler_en, 1'b0);
      m_mode = 3;
      gap(20);
      vs_pulse("wdog_recover");
`else
      cnt = 0;
      gap(300);
      chk("nowdog.lost", lost, 1'b0);
      chk("nowdog.scaler_en", scaler_en, 1'b1);
      vs_pulse("nowdog_vs");
`endif

      // Asynchronous reset mid-frame with a request pending.
      gap(10);
      request("req_pre_reset", 640, 480);
      gap(5);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      step();
      m_mode = 1;
      gap(20);
      vs_pulse("post_reset_vs");
      chk("post_reset.ready", cfg_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
